cpu7_ifu_ibuf: RTL and testbench



---
 rtl/cpu7_ifu_ibuf_if.sv | 35 +++
 rtl/cpu7_ifu_ibuf.sv | 151 +++++++++++++++
 tb/tb_cpu7_ifu_ibuf.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_ifu_ibuf_if.sv
// Fetch/decode/flush bundle of the cpu7 instruction buffer.
// master = fetch/decode/exu side, slave = the buffer itself.
interface cpu7_ifu_ibuf_if #(
    parameter int PC_W  = 32,
    parameter int PTR_W = 2
);
    logic             fdp_ibuf_valid;
    logic [PC_W-1:0]  fdp_ibuf_pc;
    logic [31:0]      fdp_ibuf_inst;
    logic             fdp_ibuf_exception;
    logic [5:0]       fdp_ibuf_exccode;
    logic             ibuf_fdp_ready;
    logic             ibuf_dec_valid;
    logic [PC_W-1:0]  ibuf_dec_pc;
    logic [31:0]      ibuf_dec_inst;
    logic             ibuf_dec_exception;
    logic [5:0]       ibuf_dec_exccode;
    logic             dec_ibuf_ready;
    logic             exu_ibuf_flush;
    logic [PTR_W:0]   ibuf_count;

    modport master (
        output fdp_ibuf_valid, fdp_ibuf_pc, fdp_ibuf_inst, fdp_ibuf_exception,
               fdp_ibuf_exccode, dec_ibuf_ready, exu_ibuf_flush,
        input  ibuf_fdp_ready, ibuf_dec_valid, ibuf_dec_pc, ibuf_dec_inst,
               ibuf_dec_exception, ibuf_dec_exccode, ibuf_count
    );

    modport slave (
        input  fdp_ibuf_valid, fdp_ibuf_pc, fdp_ibuf_inst, fdp_ibuf_exception,
               fdp_ibuf_exccode, dec_ibuf_ready, exu_ibuf_flush,
        output ibuf_fdp_ready, ibuf_dec_valid, ibuf_dec_pc, ibuf_dec_inst,
               ibuf_dec_exception, ibuf_dec_exccode, ibuf_count
    );
endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// cpu7 fetch-to-decode instruction buffer: circular FIFO with flush and fault lock.
// Optional same-cycle bypass of an empty buffer: define CPU7_IBUF_BYPASS_EN.
module cpu7_ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int PTR_W = 2
) (
    input  logic            clk,
    input  logic            resetn,
    cpu7_ifu_ibuf_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             exc_mem  [DEPTH];
    logic [5:0]       code_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             exc_lock_r;

    logic [PTR_W-1:0] rd_ptr_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W:0]   count_s;
    logic             exc_lock_s;

    logic             ready_s;
    logic             bypass_s;
    logic             head_valid_s;
    logic             push_s;
    logic             pop_s;
    logic             pass_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic [PC_W-1:0]  head_pc_s;
    logic [31:0]      head_inst_s;
    logic             head_exc_s;
    logic [5:0]       head_code_s;

    // Handshake qualifiers; flush overrides both push and pop.
    always_comb begin
        ready_s = (count_r != FULL_CNT) && !exc_lock_r;
`ifdef CPU7_IBUF_BYPASS_EN
        bypass_s = (count_r == {(PTR_W+1){1'b0}}) && bus.fdp_ibuf_valid
                   && !exc_lock_r && !bus.exu_ibuf_flush;
`else
        bypass_s = 1'b0;
`endif
        head_valid_s = (count_r != {(PTR_W+1){1'b0}}) || bypass_s;
        push_s  = bus.fdp_ibuf_valid && ready_s && !bus.exu_ibuf_flush;
        pop_s   = head_valid_s && bus.dec_ibuf_ready && !bus.exu_ibuf_flush;
        // A bypassed entry consumed in the same cycle never touches storage.
        pass_s  = bypass_s && bus.dec_ibuf_ready;
        wr_en_s = push_s && !pass_s;
        rd_en_s = pop_s && !pass_s;
    end

    // Next-state for pointers, occupancy and the fault lock.
    always_comb begin
        rd_ptr_s   = rd_ptr_r;
        wr_ptr_s   = wr_ptr_r;
        count_s    = count_r;
        exc_lock_s = exc_lock_r;
        if (bus.exu_ibuf_flush) begin
            rd_ptr_s   = {PTR_W{1'b0}};
            wr_ptr_s   = {PTR_W{1'b0}};
            count_s    = {(PTR_W+1){1'b0}};
            exc_lock_s = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_s = wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_s = rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_s = count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_s = count_r - (PTR_W+1)'(1'b1);
                default: count_s = count_r;
            endcase
            if (push_s && bus.fdp_ibuf_exception) begin
                exc_lock_s = 1'b1;
            end else begin
                exc_lock_s = exc_lock_r;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            exc_lock_r <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
            count_r    <= count_s;
            exc_lock_r <= exc_lock_s;
        end
    end

    // Entry storage: written on push only, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            pc_mem[wr_ptr_r]   <= bus.fdp_ibuf_pc;
            inst_mem[wr_ptr_r] <= bus.fdp_ibuf_inst;
            exc_mem[wr_ptr_r]  <= bus.fdp_ibuf_exception;
            code_mem[wr_ptr_r] <= bus.fdp_ibuf_exccode;
        end
    end

    // Head selection; empty buffer presents all-zero data.
    always_comb begin
        head_pc_s   = {PC_W{1'b0}};
        head_inst_s = 32'h0000_0000;
        head_exc_s  = 1'b0;
        head_code_s = 6'h00;
        if (bypass_s) begin
            head_pc_s   = bus.fdp_ibuf_pc;
            head_inst_s = bus.fdp_ibuf_inst;
            head_exc_s  = bus.fdp_ibuf_exception;
            head_code_s = bus.fdp_ibuf_exccode;
        end else if (count_r != {(PTR_W+1){1'b0}}) begin
            head_pc_s   = pc_mem[rd_ptr_r];
            head_inst_s = inst_mem[rd_ptr_r];
            head_exc_s  = exc_mem[rd_ptr_r];
            head_code_s = code_mem[rd_ptr_r];
        end else begin
            head_pc_s   = {PC_W{1'b0}};
            head_inst_s = 32'h0000_0000;
            head_exc_s  = 1'b0;
            head_code_s = 6'h00;
        end
    end

    assign bus.ibuf_fdp_ready     = ready_s;
    assign bus.ibuf_dec_valid     = head_valid_s;
    assign bus.ibuf_dec_pc        = head_pc_s;
    assign bus.ibuf_dec_inst      = head_inst_s;
    assign bus.ibuf_dec_exception = head_exc_s;
    assign bus.ibuf_dec_exccode   = head_code_s;
    assign bus.ibuf_count         = count_r;
endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Directed bench for cpu7_ifu_ibuf: queue-based reference model checked every negedge,
// plus hand-computed expectations. Honours CPU7_IBUF_BYPASS_EN if defined.
module tb_cpu7_ifu_ibuf;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int PTR_W = 2;
    localparam logic [31:0] BASE = 32'h1c00_0000;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    cpu7_ifu_ibuf_if #(.PC_W(PC_W), .PTR_W(PTR_W)) bus ();
    cpu7_ifu_ibuf #(.DEPTH(DEPTH), .PC_W(PC_W), .PTR_W(PTR_W)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [5:0]  code;
    } ent_t;

    ent_t        q[$];
    logic        lock_m = 1'b0;
    logic [31:0] popped[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: entries advance on each rising edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            lock_m = 1'b0;
        end else begin
            ent_t e;
            ent_t h;
            bit   acc;
            bit   pp;
            bit   byp;
            e = '{bus.fdp_ibuf_pc, bus.fdp_ibuf_inst, bus.fdp_ibuf_exception, bus.fdp_ibuf_exccode};
            if (bus.exu_ibuf_flush) begin
                q.delete();
                lock_m = 1'b0;
            end else begin
                pp  = (q.size() > 0) && bus.dec_ibuf_ready;
                acc = bus.fdp_ibuf_valid && (q.size() < DEPTH) && !lock_m;
                byp = 1'b0;
`ifdef CPU7_IBUF_BYPASS_EN
                if (q.size() == 0 && acc && bus.dec_ibuf_ready) begin
                    byp = 1'b1;
                    popped.push_back(e.pc);
                end
`endif
                if (pp) begin
                    h = q.pop_front();
                    popped.push_back(h.pc);
                end
                if (acc && !byp) q.push_back(e);
                if (acc && e.exc) lock_m = 1'b1;
            end
        end
    end

    // Compare all outputs against the model each falling edge.
    always @(negedge clk) begin
        ent_t hd;
        logic ev;
        ev = (q.size() > 0);
        hd = ev ? q[0] : '0;
`ifdef CPU7_IBUF_BYPASS_EN
        if (!ev && bus.fdp_ibuf_valid && !lock_m && !bus.exu_ibuf_flush) begin
            ev = 1'b1;
            hd = '{bus.fdp_ibuf_pc, bus.fdp_ibuf_inst, bus.fdp_ibuf_exception, bus.fdp_ibuf_exccode};
        end
`endif
        chk("m_ready", 64'(bus.ibuf_fdp_ready), 64'((q.size() < DEPTH) && !lock_m));
        chk("m_valid", 64'(bus.ibuf_dec_valid), 64'(ev));
        chk("m_count", 64'(bus.ibuf_count), 64'(q.size()));
        chk("m_pc",    64'(bus.ibuf_dec_pc), 64'(hd.pc));
        chk("m_inst",  64'(bus.ibuf_dec_inst), 64'(hd.inst));
        chk("m_exc",   64'(bus.ibuf_dec_exception), 64'(hd.exc));
        chk("m_code",  64'(bus.ibuf_dec_exccode), 64'(hd.code));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic exc,
                         input logic [5:0] code, input logic rdy, input logic fl);
        bus.fdp_ibuf_valid     = v;
        bus.fdp_ibuf_pc        = pc;
        bus.fdp_ibuf_inst      = pc ^ 32'hdead_beef;
        bus.fdp_ibuf_exception = exc;
        bus.fdp_ibuf_exccode   = code;
        bus.dec_ibuf_ready     = rdy;
        bus.exu_ibuf_flush     = fl;
    endtask

    initial begin
        int idx;
        bit acc;
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0);
        #1 resetn = 1'b0;
        #2;
        chk("rst_valid", 64'(bus.ibuf_dec_valid), 64'd0);
        chk("rst_ready", 64'(bus.ibuf_fdp_ready), 64'd1);
        chk("rst_count", 64'(bus.ibuf_count), 64'd0);
        chk("rst_pc",    64'(bus.ibuf_dec_pc), 64'd0);
        step();
        step();
        resetn = 1'b1;

        // Fill to full, then a fifth offer must be refused.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, BASE + 32'(4 * i), 1'b0, 6'h00, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, BASE + 32'h10, 1'b0, 6'h00, 1'b0, 1'b0);
        step();
        chk("full_count", 64'(bus.ibuf_count), 64'd4);
        chk("full_ready", 64'(bus.ibuf_fdp_ready), 64'd0);
        chk("full_pc",    64'(bus.ibuf_dec_pc), 64'h1c00_0000);
        chk("full_inst",  64'(bus.ibuf_dec_inst), 64'(32'h1c00_0000 ^ 32'hdead_beef));

        drive(1'b1, BASE + 32'h10, 1'b0, 6'h00, 1'b1, 1'b0);
        step();
        chk("pop1_count", 64'(bus.ibuf_count), 64'd3);
        chk("pop1_ready", 64'(bus.ibuf_fdp_ready), 64'd1);
        chk("pop1_pc",    64'(bus.ibuf_dec_pc), 64'h1c00_0004);

        // Stream with an irregular decode pattern so pointers wrap several times.
        idx = 4;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, BASE + 32'(4 * idx), 1'b0, 6'h00, 1'((i % 3) != 0), 1'b0);
            acc = (q.size() < DEPTH) && !lock_m;
            step();
            if (acc) idx++;
        end
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b1, 1'b0);
        repeat (6) step();
        chk("stream_len_ge14", 64'(idx >= 14), 64'd1);
        chk("stream_popped", 64'(popped.size()), 64'(idx));
        for (int k = 0; k < popped.size(); k++)
            chk("stream_order", 64'(popped[k]), 64'(BASE + 32'(4 * k)));
        chk("drain_valid", 64'(bus.ibuf_dec_valid), 64'd0);

        // Faulting fetch locks the fetch side until a flush.
        drive(1'b1, BASE + 32'h200, 1'b1, 6'h08, 1'b0, 1'b0);
        step();
        drive(1'b1, BASE + 32'h204, 1'b0, 6'h00, 1'b0, 1'b0);
        step();
        chk("exc_ready", 64'(bus.ibuf_fdp_ready), 64'd0);
        chk("exc_count", 64'(bus.ibuf_count), 64'd1);
        chk("exc_pc",    64'(bus.ibuf_dec_pc), 64'h1c00_0200);
        chk("exc_flag",  64'(bus.ibuf_dec_exception), 64'd1);
        chk("exc_code",  64'(bus.ibuf_dec_exccode), 64'h08);
        drive(1'b1, BASE + 32'h204, 1'b0, 6'h00, 1'b1, 1'b0);
        step();
        chk("exc_drained", 64'(bus.ibuf_dec_valid), 64'd0);
        chk("exc_still_locked", 64'(bus.ibuf_fdp_ready), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("unlock_ready", 64'(bus.ibuf_fdp_ready), 64'd1);
        chk("unlock_count", 64'(bus.ibuf_count), 64'd0);

        // Flush wins over a simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, BASE + 32'h280 + 32'(4 * i), 1'b0, 6'h00, 1'b0, 1'b0);
            step();
        end
        chk("pre_flush_count", 64'(bus.ibuf_count), 64'd3);
        drive(1'b1, BASE + 32'h300, 1'b0, 6'h00, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("flush_count", 64'(bus.ibuf_count), 64'd0);
        chk("flush_valid", 64'(bus.ibuf_dec_valid), 64'd0);
        step();
        chk("flush_no_ghost", 64'(bus.ibuf_dec_valid), 64'd0);

        // Asynchronous reset between edges with two entries held.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, BASE + 32'h400 + 32'(4 * i), 1'b0, 6'h00, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("arst_pre_count", 64'(bus.ibuf_count), 64'd2);
        #1 resetn = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.ibuf_dec_valid), 64'd0);
        chk("arst_count", 64'(bus.ibuf_count), 64'd0);
        step();
        resetn = 1'b1;
        step();

        // Empty-buffer entry with decode ready: same-cycle only with bypass.
        drive(1'b1, BASE + 32'h100, 1'b0, 6'h00, 1'b1, 1'b0);
        #1;
`ifdef CPU7_IBUF_BYPASS_EN
        chk("byp_valid", 64'(bus.ibuf_dec_valid), 64'd1);
        chk("byp_pc",    64'(bus.ibuf_dec_pc), 64'h1c00_0100);
`else
        chk("nobyp_valid", 64'(bus.ibuf_dec_valid), 64'd0);
        chk("nobyp_pc",    64'(bus.ibuf_dec_pc), 64'd0);
`endif
        step();
        drive(1'b0, 32'h0, 1'b0, 6'h00, 1'b1, 1'b0);
`ifdef CPU7_IBUF_BYPASS_EN
        chk("byp_count", 64'(bus.ibuf_count), 64'd0);
        chk("byp_after_valid", 64'(bus.ibuf_dec_valid), 64'd0);
`else
        chk("nobyp_count", 64'(bus.ibuf_count), 64'd1);
        chk("nobyp_late_valid", 64'(bus.ibuf_dec_valid), 64'd1);
        chk("nobyp_late_pc", 64'(bus.ibuf_dec_pc), 64'h1c00_0100);
`endif
        step();
        chk("byp_end_count", 64'(bus.ibuf_count), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
